// File: rtl/dpram_hs_if.sv
// Per-port request/response bundle for dpram_hs: valid/ready request with
// write strobes, plus a valid/ready response carrying q.
interface dpram_hs_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) ();
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   be;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     q;

    modport master (
        output valid, we, addr, data, be, rready,
        input  ready, rvalid, q
    );

    modport slave (
        input  valid, we, addr, data, be, rready,
        output ready, rvalid, q
    );
endinterface

// File: rtl/dpram_hs.sv
// dpram_hs: true dual-port RAM with per-port handshakes, byte strobes and
// write-first cross-port forwarding. DPRAM_CLEAR_EN adds a zeroing pass after reset.
module dpram_hs #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dpram_hs_if.slave        port_a,
    dpram_hs_if.slave        port_b,
    output logic             collision,
    output logic [CNT_W-1:0] coll_cnt,
    output logic             busy
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned BE_W  = DATA_W/8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef DPRAM_CLEAR_EN
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            if (clr_addr_q == '1) begin
                state_d = ST_RUN;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign run      = (state_q == ST_RUN);
    assign busy     = (state_q == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_addr_q;
`else
    assign run      = 1'b1;
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
    logic              coll_q;
    logic [CNT_W-1:0]  coll_cnt_q, coll_cnt_d;

    logic              ready_a, ready_b;
    logic              acc_a, acc_b, wr_a, wr_b;
    logic              same_addr, both_wr;
    logic [DATA_W-1:0] old_a, old_b, mrg_a, mrg_b, rsp_a, rsp_b;

    // Ready depends only on registered state and the response-side rready.
    assign ready_a = run & (~rvalid_a_q | port_a.rready);
    assign ready_b = run & (~rvalid_b_q | port_b.rready);

    assign acc_a     = port_a.valid & ready_a;
    assign acc_b     = port_b.valid & ready_b;
    assign wr_a      = acc_a & port_a.we;
    assign wr_b      = acc_b & port_b.we;
    assign same_addr = (port_a.addr == port_b.addr);
    assign both_wr   = wr_a & wr_b & same_addr;

    assign old_a = mem[port_a.addr];
    assign old_b = mem[port_b.addr];
    assign mrg_a = merge(old_a, port_a.data, port_a.be);
    assign mrg_b = merge(old_b, port_b.data, port_b.be);

    // Write-first across ports; on a write/write clash port A wins for both.
    always_comb begin
        rsp_a = old_a;
        rsp_b = old_b;
        if (wr_a)                  rsp_a = mrg_a;
        else if (wr_b & same_addr) rsp_a = mrg_b;
        if (both_wr)               rsp_b = mrg_a;
        else if (wr_b)             rsp_b = mrg_b;
        else if (wr_a & same_addr) rsp_b = mrg_a;
    end

    always_comb begin
        rvalid_a_d = rvalid_a_q;
        q_a_d      = q_a_q;
        if (acc_a) begin
            rvalid_a_d = 1'b1;
            q_a_d      = rsp_a;
        end else if (port_a.rready) begin
            rvalid_a_d = 1'b0;
        end
    end

    always_comb begin
        rvalid_b_d = rvalid_b_q;
        q_b_d      = q_b_q;
        if (acc_b) begin
            rvalid_b_d = 1'b1;
            q_b_d      = rsp_b;
        end else if (port_b.rready) begin
            rvalid_b_d = 1'b0;
        end
    end

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (both_wr && (coll_cnt_q != '1)) coll_cnt_d = coll_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            q_a_q      <= '0;
            q_b_q      <= '0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            q_a_q      <= q_a_d;
            q_b_q      <= q_b_d;
            coll_q     <= both_wr;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    // Array is never reset; B's write is suppressed when it clashes with A's.
    always_ff @(posedge clk) begin
        if (clr_we)            mem[clr_addr]    <= '0;
        if (wr_a)              mem[port_a.addr] <= mrg_a;
        if (wr_b && !both_wr)  mem[port_b.addr] <= mrg_b;
    end

    assign port_a.ready  = ready_a;
    assign port_b.ready  = ready_b;
    assign port_a.rvalid = rvalid_a_q;
    assign port_b.rvalid = rvalid_b_q;
    assign port_a.q      = q_a_q;
    assign port_b.q      = q_b_q;
    assign collision     = coll_q;
    assign coll_cnt      = coll_cnt_q;
endmodule

// File: tb/tb_dpram_hs.sv
// Randomised and directed bench for dpram_hs (DATA_W=32, ADDR_W=4, CNT_W=2)
// against a memory-array reference model; honours DPRAM_CLEAR_EN.
module tb_dpram_hs;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned BW = DW/8;
    localparam int unsigned DEPTH = 2**AW;
    localparam int CNT_MAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          collision;
    logic [CW-1:0] coll_cnt;
    logic          busy;

    dpram_hs_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
    dpram_hs_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

    dpram_hs #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .port_a    (a_if),
        .port_b    (b_if),
        .collision (collision),
        .coll_cnt  (coll_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: storage array plus per-port pending response.
    logic [DW-1:0] mm [DEPTH];
    bit            m_run;
    bit            m_rv_a, m_rv_b;
    logic [DW-1:0] m_q_a, m_q_b;
    bit            m_coll;
    int            m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] d,
                                               input logic [BW-1:0] be);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < int'(BW); i++)
            if (be[i]) mask = mask | (DW'(8'hFF) << (8*i));
        return (old_w & ~mask) | (d & mask);
    endfunction

    task automatic check_outputs();
        check("rvalid_a", a_if.rvalid, m_rv_a);
        check("q_a", a_if.q, m_q_a);
        check("rvalid_b", b_if.rvalid, m_rv_b);
        check("q_b", b_if.q, m_q_b);
        check("collision", collision, m_coll);
        check("coll_cnt", coll_cnt, m_cnt);
        check("busy", busy, !m_run);
    endtask

    // One clock of traffic; entered and left at a falling edge.
    task automatic step(input bit va, input bit wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic [BW-1:0] ba, input bit rra,
                        input bit vb, input bit wb, input logic [AW-1:0] ab,
                        input logic [DW-1:0] db, input logic [BW-1:0] bb, input bit rrb);
        bit acc_a, acc_b, exp_ra, exp_rb, wa_e, wb_e, clash;
        logic [DW-1:0] nw_a, nw_b, rd_a, rd_b;
        a_if.valid = va; a_if.we = wa; a_if.addr = aa; a_if.data = da; a_if.be = ba; a_if.rready = rra;
        b_if.valid = vb; b_if.we = wb; b_if.addr = ab; b_if.data = db; b_if.be = bb; b_if.rready = rrb;
        #1;
        exp_ra = m_run && (!m_rv_a || rra);
        exp_rb = m_run && (!m_rv_b || rrb);
        check("ready_a", a_if.ready, exp_ra);
        check("ready_b", b_if.ready, exp_rb);
        acc_a = va && exp_ra;
        acc_b = vb && exp_rb;
        wa_e  = acc_a && wa;
        wb_e  = acc_b && wb;
        clash = wa_e && wb_e && (aa == ab);
        nw_a  = apply_be(mm[aa], da, ba);
        nw_b  = apply_be(mm[ab], db, bb);
        // A read sees whatever the memory holds after this cycle's write(s).
        rd_a = mm[aa];
        rd_b = mm[ab];
        if (wb_e && !clash && aa == ab) rd_a = nw_b;
        if (wa_e && aa == ab) rd_b = nw_a;
        @(posedge clk);
        if (wb_e && !clash) mm[ab] = nw_b;
        if (wa_e) mm[aa] = nw_a;
        if (acc_a) begin m_rv_a = 1; m_q_a = wa_e ? nw_a : rd_a; end
        else if (rra) m_rv_a = 0;
        if (acc_b) begin m_rv_b = 1; m_q_b = clash ? nw_a : (wb_e ? nw_b : rd_b); end
        else if (rrb) m_rv_b = 0;
        m_coll = clash;
        if (clash && m_cnt < CNT_MAX) m_cnt++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, '0, '0, '0, 1, 0, 0, '0, '0, '0, 1);
    endtask

    task automatic reset_pulse();
        a_if.valid = 0; b_if.valid = 0; a_if.rready = 1; b_if.rready = 1;
        a_if.we = 0; b_if.we = 0; a_if.addr = '0; b_if.addr = '0;
        a_if.data = '0; b_if.data = '0; a_if.be = '0; b_if.be = '0;
        rst_n = 0;
        #1;
        m_rv_a = 0; m_rv_b = 0; m_q_a = '0; m_q_b = '0; m_coll = 0; m_cnt = 0;
`ifdef DPRAM_CLEAR_EN
        m_run = 0;
`else
        m_run = 1;
`endif
        check_outputs();
        check("ready_a_rst", a_if.ready, m_run);
        check("ready_b_rst", b_if.ready, m_run);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

`ifdef DPRAM_CLEAR_EN
    task automatic clear_wait(input int abort_at);
        check("busy_rel", busy, 1);
        check("ready_rel", a_if.ready, 0);
        for (int k = 1; k <= int'(DEPTH); k++) begin
            if (k == abort_at) return;
            @(posedge clk);
            @(negedge clk);
            check("clr_busy", busy, k < int'(DEPTH));
            check("clr_ready_a", a_if.ready, k == int'(DEPTH));
            check("clr_ready_b", b_if.ready, k == int'(DEPTH));
        end
        m_run = 1;
        for (int i = 0; i < int'(DEPTH); i++) mm[i] = '0;
    endtask
`endif

    task automatic do_reset();
        reset_pulse();
`ifdef DPRAM_CLEAR_EN
        clear_wait(0);
`endif
    endtask

    initial begin
        int exp_seq [5] = '{1, 2, 3, 3, 3};
        logic [DW-1:0] held;
        @(negedge clk);
        do_reset();

`ifdef DPRAM_CLEAR_EN
        for (int i = 0; i < int'(DEPTH); i += 2) begin
            step(1, 0, AW'(i), '0, '0, 1, 1, 0, AW'(i+1), '0, '0, 1);
            check("clr_zero_a", a_if.q, 0);
            check("clr_zero_b", b_if.q, 0);
        end
        idle();
        reset_pulse();
        clear_wait(8);
        reset_pulse();
        clear_wait(0);
`endif

        for (int i = 0; i < int'(DEPTH); i++)
            step(1, 1, AW'(i), DW'($urandom), '1, 1, 0, 0, '0, '0, '0, 1);

        // Single byte lane write, then read from the other port.
        step(1, 1, AW'(3), DW'(32'hA5), 4'h1, 1, 0, 0, '0, '0, '0, 1);
        check("wr_a5_low", a_if.q[7:0], 8'hA5);
        step(0, 0, '0, '0, '0, 1, 1, 0, AW'(3), '0, '0, 1);
        check("rd_a5_low", b_if.q[7:0], 8'hA5);

        step(1, 1, AW'(5), 32'h11223344, 4'hF, 1, 0, 0, '0, '0, '0, 1);
        step(1, 1, AW'(5), 32'hAABBCCDD, 4'h2, 1, 0, 0, '0, '0, '0, 1);
        step(1, 0, AW'(5), '0, '0, 1, 0, 0, '0, '0, '0, 1);
        check("be_merge", a_if.q, 32'h1122CC44);
        step(1, 1, AW'(5), 32'hFFFFFFFF, 4'h0, 1, 0, 0, '0, '0, '0, 1);
        check("be_zero", a_if.q, 32'h1122CC44);

        step(1, 1, AW'(7), 32'h01, 4'hF, 1, 1, 1, AW'(7), 32'h02, 4'hF, 1);
        check("coll_qa", a_if.q, 32'h01);
        check("coll_qb", b_if.q, 32'h01);
        check("coll_pulse", collision, 1);
        check("coll_cnt1", coll_cnt, 1);
        step(1, 1, AW'(7), 32'h05, 4'hF, 1, 1, 0, AW'(7), '0, '0, 1);
        check("wf_qb", b_if.q, 32'h05);
        check("wf_nocoll", collision, 0);
        step(1, 0, AW'(7), '0, '0, 1, 1, 1, AW'(7), 32'h09, 4'h1, 1);
        check("wf_qa_from_b", a_if.q, 32'h09);

        // Reset while a response is held outstanding.
        step(1, 0, AW'(2), '0, '0, 0, 0, 0, '0, '0, '0, 1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 1, AW'(1), DW'($urandom), '1, 1, 1, 1, AW'(1), DW'($urandom), '1, 1);
            check("cnt_sat", coll_cnt, exp_seq[i]);
        end

        // Back-pressure port A while port B keeps streaming.
        step(1, 0, AW'(0), '0, '0, 1, 0, 0, '0, '0, '0, 1);
        held = a_if.q;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, AW'(9), '0, '0, 0, 1, i[0], AW'($urandom_range(1, 15)), DW'($urandom), BW'($urandom), 1);
            check("bp_hold", a_if.q, held);
            check("bp_ready", a_if.ready, 0);
        end
        step(1, 0, AW'(9), '0, '0, 1, 0, 0, '0, '0, '0, 1);
        check("bp_release", a_if.q, mm[9]);

        for (int i = 0; i < 1500; i++) begin
            logic [AW-1:0] ra, rb;
            ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, DW'($urandom), BW'($urandom),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rb, DW'($urandom), BW'($urandom),
                 $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
